// File: rtl/game_pkg.sv
// Shared constants for the memory-game controller: state codes,
// debounce default and display-select values.
package game_pkg;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SEQ    = 3'd2;
    localparam logic [2:0] S_USER   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_RESULT = 3'd6;

    localparam int DEBOUNCE_CYCLES_DEF = 500_000;
    localparam int CNT_W_DEF           = 19;

    localparam logic SEL_GAME   = 1'b1;
    localparam logic SEL_RESULT = 1'b0;

endpackage

// File: rtl/game_if.sv
// Controller <-> datapath bundle: status flags in, command strobes out
// (master = controller side, slave = datapath side).
interface game_if;

    logic end_fpga;
    logic end_user;
    logic end_time;
    logic win;
    logic match;

    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;

    modport master (
        input  end_fpga, end_user, end_time, win, match,
        output r1, r2, e1, e2, e3, e4, sel
    );

    modport slave (
        output end_fpga, end_user, end_time, win, match,
        input  r1, r2, e1, e2, e3, e4, sel
    );

endinterface

// File: rtl/key_pulse.sv
// ENTER conditioning: 2-flop sync, optional debounce, rising-edge pulse.
// Debounce filter is built only when DEBOUNCE_EN is defined.
module key_pulse
    import game_pkg::*;
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
)
`endif
(
    input  logic clock_50,
    input  logic reset,
    input  logic enter,
    output logic press
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic r_press;
    logic w_lvl;

    // Sync flops reset high so a key held through reset looks "already
    // pressed" and never produces an edge on release.
    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= enter;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_filt <= 1'b1;
            r_cnt  <= '0;
        end else if (r_sync2 != r_filt) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync2;
`endif

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_hist  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_hist  <= w_lvl;
            r_press <= w_lvl & ~r_hist;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/game_controller.sv
// Memory-game control FSM driving the datapath strobes.
// Define DEBOUNCE_EN to enable the ENTER debounce filter.
module game_controller
    import game_pkg::*;
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
)
`endif
(
    input  logic   clock_50,
    input  logic   reset,
    input  logic   enter,
    game_if.master dp
);

    logic       w_press;
    logic [2:0] r_state;
    logic [2:0] w_next;

`ifdef DEBOUNCE_EN
    key_pulse #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key (
`else
    key_pulse u_key (
`endif
        .clock_50 (clock_50),
        .reset    (reset),
        .enter    (enter),
        .press    (w_press)
    );

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   if (w_press) w_next = S_SETUP;
            S_SETUP:  if (w_press) w_next = S_SEQ;
            S_SEQ:    if (dp.end_fpga) w_next = S_USER;
            S_USER: begin
                if (dp.end_time) begin
                    w_next = S_RESULT;
                end else if (dp.end_user) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!dp.match || dp.win) begin
                    w_next = S_RESULT;
                end else begin
                    w_next = S_NEXT;
                end
            end
            S_NEXT:   w_next = S_SEQ;
            S_RESULT: if (w_press) w_next = S_INIT;
            default:  w_next = S_INIT;
        endcase
    end

    // e4 is the one Mealy output: a press only counts as an entry when
    // the round is not ending in the same cycle.
    always_comb begin
        dp.r1  = 1'b0;
        dp.r2  = 1'b0;
        dp.e1  = 1'b0;
        dp.e2  = 1'b0;
        dp.e3  = 1'b0;
        dp.e4  = 1'b0;
        dp.sel = SEL_GAME;
        case (r_state)
            S_INIT: begin
                dp.r1 = 1'b1;
                dp.r2 = 1'b1;
            end
            S_SETUP: dp.e1 = 1'b1;
            S_SEQ:   dp.e3 = 1'b1;
            S_USER: begin
                dp.e2 = 1'b1;
                dp.e4 = w_press & ~dp.end_time & ~dp.end_user;
            end
            S_CHECK:  dp.sel = SEL_GAME;
            S_NEXT:   dp.r2 = 1'b1;
            S_RESULT: dp.sel = SEL_RESULT;
            default: begin
                dp.r1 = 1'b1;
                dp.r2 = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios then random play,
// every cycle checked against a behavioural game model.
module tb_game_controller;

    typedef enum {
        M_INIT, M_SETUP, M_SEQ, M_USER, M_CHECK, M_NEXT, M_RESULT
    } mstate_t;

`ifdef DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic enter;

    game_if u_if ();

`ifdef DEBOUNCE_EN
    game_controller #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
`else
    game_controller dut (
`endif
        .clock_50 (clk),
        .reset    (rst_n),
        .enter    (enter),
        .dp       (u_if)
    );

    int    vecs = 0;
    int    errs = 0;
    string tag  = "reset";

    // Model: game phase plus a key-path timeline (sampled level,
    // synchronised level, accepted level, edge history, visible press).
    mstate_t ms;
    logic    m_e;
    logic    m_s2;
    logic    m_lvl;
    logic    m_hist;
    logic    m_press;
    logic    m_filt;
    int      m_cnt;

    function automatic logic [6:0] exp_out(mstate_t s, logic p,
                                           logic et, logic eu);
        logic [6:0] v;
        case (s)
            M_INIT:   v = 7'b1100001;
            M_SETUP:  v = 7'b0010001;
            M_SEQ:    v = 7'b0000101;
            M_USER:   v = {5'b00010, p & ~et & ~eu, 1'b1};
            M_CHECK:  v = 7'b0000001;
            M_NEXT:   v = 7'b0100001;
            default:  v = 7'b0000000;
        endcase
        return v;
    endfunction

    task automatic model_edge(input logic en, input logic rs,
                              input logic ef, input logic eu,
                              input logic et, input logic w,
                              input logic mt);
        logic p;
        logic r;
        logic s2_n;
        logic lvl_n;
        p = m_press;
        r = !rs;
        if (r) begin
            ms = M_INIT;
        end else begin
            case (ms)
                M_INIT:   if (p) ms = M_SETUP;
                M_SETUP:  if (p) ms = M_SEQ;
                M_SEQ:    if (ef) ms = M_USER;
                M_USER: begin
                    if (et) ms = M_RESULT;
                    else if (eu) ms = M_CHECK;
                end
                M_CHECK:  ms = (mt && !w) ? M_NEXT : M_RESULT;
                M_NEXT:   ms = M_SEQ;
                default:  if (p) ms = M_INIT;
            endcase
        end
        s2_n = r ? 1'b1 : m_e;
`ifdef DEBOUNCE_EN
        if (r) begin
            m_filt = 1'b1;
            m_cnt  = 0;
        end else if (m_s2 != m_filt) begin
            m_cnt++;
            if (m_cnt == DB) begin
                m_filt = m_s2;
                m_cnt  = 0;
            end
        end else begin
            m_cnt = 0;
        end
        lvl_n = m_filt;
`else
        lvl_n = s2_n;
`endif
        m_press = r ? 1'b0 : (m_lvl & ~m_hist);
        m_hist  = r ? 1'b1 : m_lvl;
        m_lvl   = lvl_n;
        m_s2    = s2_n;
        m_e     = r ? 1'b1 : en;
    endtask

    task automatic cyc(input logic en, input logic rs,
                       input logic ef, input logic eu,
                       input logic et, input logic w,
                       input logic mt);
        logic [6:0] obs;
        logic [6:0] exp_v;
        enter           = en;
        rst_n           = rs;
        u_if.end_fpga   = ef;
        u_if.end_user   = eu;
        u_if.end_time   = et;
        u_if.win        = w;
        u_if.match      = mt;
        @(negedge clk);
        obs = {u_if.r1, u_if.r2, u_if.e1, u_if.e2,
               u_if.e3, u_if.e4, u_if.sel};
        exp_v = exp_out(ms, m_press, et, eu);
        vecs++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: r1r2e1e2e3e4sel got %b want %b",
                   tag, obs, exp_v);
        end
        @(posedge clk);
        model_edge(en, rs, ef, eu, et, w, mt);
        #1;
    endtask

    task automatic idle(input logic en, input int n);
        for (int i = 0; i < n; i++) cyc(en, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic press_key();
        idle(1'b1, DB + 3);
        idle(1'b0, DB + 3);
    endtask

    task automatic to_user();
        press_key();
        press_key();
        cyc(0, 1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        enter         = 1'b1;
        u_if.end_fpga = 1'b0;
        u_if.end_user = 1'b0;
        u_if.end_time = 1'b0;
        u_if.win      = 1'b0;
        u_if.match    = 1'b0;
        @(posedge clk);
        #1;
        ms      = M_INIT;
        m_e     = 1'b1;
        m_s2    = 1'b1;
        m_lvl   = 1'b1;
        m_hist  = 1'b1;
        m_press = 1'b0;
        m_filt  = 1'b1;
        m_cnt   = 0;

        tag = "reset";
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        tag = "held_through_reset";
        idle(1'b1, DB + 6);
        idle(1'b0, DB + 4);

        tag = "win_path";
        to_user();
        for (int k = 0; k < 3; k++) press_key();
        cyc(0, 1, 0, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(1'b0, 2);
        press_key();

        tag = "multi_round";
        to_user();
        cyc(0, 1, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 1);
        idle(1'b0, 3);
        cyc(0, 1, 1, 0, 0, 0, 0);

        tag = "mismatch";
        cyc(0, 1, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(1'b0, 2);
        press_key();

        tag = "timeout_prio";
        to_user();
        for (int i = 0; i < DB + 6; i++) begin
            cyc(1, 1, 0, m_press, m_press, 0, 1);
        end
        idle(1'b0, DB + 3);
        press_key();

        tag = "bounce";
        idle(1'b0, DB + 3);
        idle(1'b1, 2);
        idle(1'b0, 2);
        idle(1'b1, 6);
        idle(1'b0, DB + 6);
        cyc(0, 0, 0, 0, 0, 0, 0);

        tag = "midgame_reset";
        idle(1'b0, 2);
        to_user();
        cyc(0, 0, 0, 0, 0, 0, 0);
        idle(1'b0, 3);

        tag = "random";
        for (int n = 0; n < 400; n++) begin
            int   run;
            logic lv;
            run = int'($urandom_range(1, DB + 6));
            lv  = 1'($urandom_range(0, 1));
            for (int i = 0; i < run; i++) begin
                cyc(lv,
                    ($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
